rf_writeback_arbiter: RTL and testbench

// - Write-side requester for the 32x64 register file: merges ALU and LSU results into one wen/waddr/wdata port.
// - Each source uses a valid/ready handshake. Accepted results are buffered in an in-order FIFO.
// - The FIFO drains one register write per cycle onto the register file write port.
// - Writes to x0 are dropped here, so the register file never sees them.

---
 rtl/rf_writeback_arbiter_if.sv | 27 ++
 rtl/rf_writeback_arbiter.sv | 111 +++++++++++
 tb/tb_rf_writeback_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback bus between the ALU/LSU result producers, the arbiter, and the register file write port.
// The master modport belongs to the producers and the register file; the slave modport belongs to the arbiter.
interface rf_writeback_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [4:0]            alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [4:0]            lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  rf_wen;
    logic [4:0]            rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and LSU results through an in-order FIFO onto one register file write port, dropping x0 writes.
// Define WB_BYPASS_EN to add the two combinational bypass lookup ports.
module rf_writeback_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rf_writeback_arbiter_if.slave    wb,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]               byp_rs1,
    input  logic [4:0]               byp_rs2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DATA_WIDTH-1:0]    byp_data1,
    output logic [DATA_WIDTH-1:0]    byp_data2
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 5 + DATA_WIDTH;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] alu_slot;
    logic [CW-1:0] free;
    logic          lsu_push;
    logic          alu_push;
    logic          pop;
    logic [EW-1:0] head;

    // Handshake: a transfer happens on a cycle where valid and ready are both high at the
    // rising edge; ready depends only on registered occupancy (and lsu_valid for the ALU),
    // so a pop in the same cycle never frees a slot early. LSU wins the last free slot.
    assign free         = CW'(DEPTH) - count;
    assign wb.lsu_ready = (free != '0);
    assign wb.alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !wb.lsu_valid);

    assign lsu_push = wb.lsu_valid && wb.lsu_ready && (wb.lsu_rd != 5'd0);
    assign alu_push = wb.alu_valid && wb.alu_ready && (wb.alu_rd != 5'd0);
    assign pop      = (count != '0);
    assign head     = mem[rd_ptr];
    assign alu_slot = wr_ptr + PW'(lsu_push);
    assign idle     = (count == '0) && !wb.rf_wen;

    // LSU entry is older than an ALU entry accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (lsu_push) mem[wr_ptr]   <= {wb.lsu_rd, wb.lsu_data};
        if (alu_push) mem[alu_slot] <= {wb.alu_rd, wb.alu_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wb.rf_wen   <= 1'b0;
            wb.rf_waddr <= '0;
            wb.rf_wdata <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(lsu_push) + PW'(alu_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
            wb.rf_wen <= pop;
            if (pop) begin
                wb.rf_waddr <= head[EW-1:DATA_WIDTH];
                wb.rf_wdata <= head[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [4:0]            byp_rs   [2];
    logic                  byp_hit  [2];
    logic [DATA_WIDTH-1:0] byp_data [2];
    logic [EW-1:0]         byp_ent;

    assign byp_rs[0] = byp_rs1;
    assign byp_rs[1] = byp_rs2;
    assign byp_hit1  = byp_hit[0];
    assign byp_hit2  = byp_hit[1];
    assign byp_data1 = byp_data[0];
    assign byp_data2 = byp_data[1];

    // Scan oldest (register stage) to youngest FIFO entry so the last match wins.
    always_comb begin
        byp_ent = '0;
        for (int k = 0; k < 2; k++) begin
            byp_hit[k]  = 1'b0;
            byp_data[k] = '0;
            if (byp_rs[k] != 5'd0) begin
                if (wb.rf_wen && (wb.rf_waddr == byp_rs[k])) begin
                    byp_hit[k]  = 1'b1;
                    byp_data[k] = wb.rf_wdata;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    byp_ent = mem[rd_ptr + PW'(i)];
                    if ((CW'(i) < count) && (byp_ent[EW-1:DATA_WIDTH] == byp_rs[k])) begin
                        byp_hit[k]  = 1'b1;
                        byp_data[k] = byp_ent[DATA_WIDTH-1:0];
                    end
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_writeback_arbiter;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int EW    = 5 + DW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CW-1:0] count;
    logic          idle;

    rf_writeback_arbiter_if #(.DATA_WIDTH(DW)) wbi ();

`ifdef WB_BYPASS_EN
    logic [4:0]    byp_rs1 = 5'd0;
    logic [4:0]    byp_rs2 = 5'd0;
    logic          byp_hit1, byp_hit2;
    logic [DW-1:0] byp_data1, byp_data2;
`endif

    rf_writeback_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wbi),
        .count (count),
        .idle  (idle)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1   (byp_rs1),
        .byp_rs2   (byp_rs2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pending results in a queue, plus the write-port register contents.
    logic [EW-1:0] model_q [$];
    logic [EW-1:0] exp_q [$];
    logic          m_wen;
    logic [4:0]    m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_lsu_ready, m_alu_ready;
    logic          obs_lsu_ready, obs_alu_ready;
    int            n_total = 0;
    int            n_bad   = 0;

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // Drive one cycle of inputs, sample readies before the edge, advance the model at the edge.
    task automatic step(input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld,
                        input logic av, input logic [4:0] ard, input logic [DW-1:0] ad);
        int            free;
        logic [EW-1:0] ent;
        wbi.lsu_valid = lv; wbi.lsu_rd = lrd; wbi.lsu_data = ld;
        wbi.alu_valid = av; wbi.alu_rd = ard; wbi.alu_data = ad;
        #2;
        obs_lsu_ready = wbi.lsu_ready;
        obs_alu_ready = wbi.alu_ready;
        free = DEPTH - model_q.size();
        m_lsu_ready = (free >= 1);
        m_alu_ready = (free >= 2) || (free == 1 && !lv);
        @(posedge clk);
        if (model_q.size() > 0) begin
            ent = model_q.pop_front();
            m_wen = 1'b1; m_waddr = ent[EW-1:DW]; m_wdata = ent[DW-1:0];
        end else begin
            m_wen = 1'b0;
        end
        if (lv && m_lsu_ready && lrd != 5'd0) begin
            model_q.push_back({lrd, ld}); exp_q.push_back({lrd, ld});
        end
        if (av && m_alu_ready && ard != 5'd0) begin
            model_q.push_back({ard, ad}); exp_q.push_back({ard, ad});
        end
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic test_reset();
        wbi.lsu_valid = 1'b0; wbi.lsu_rd = '0; wbi.lsu_data = '0;
        wbi.alu_valid = 1'b0; wbi.alu_rd = '0; wbi.alu_data = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (wbi.rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %0b want 0", wbi.rf_wen); end
        n_total++; if (wbi.rf_waddr !== 5'd0) begin n_bad++; $display("FAIL reset_waddr: got %0d want 0", wbi.rf_waddr); end
        n_total++; if (wbi.rf_wdata !== 64'd0) begin n_bad++; $display("FAIL reset_wdata: got %0h want 0", wbi.rf_wdata); end
        n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %0b want 1", idle); end
        n_total++; if (wbi.lsu_ready !== 1'b1 || wbi.alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got lsu=%0b alu=%0b want 1/1", wbi.lsu_ready, wbi.alu_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_alu();
        step(1'b0, 5'd0, '0, 1'b1, 5'd5, 64'h1234);
        n_total++; if (obs_alu_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %0b want 1", obs_alu_ready); end
        n_total++; if (wbi.rf_wen !== 1'b0 || count !== 3'd1) begin
            n_bad++; $display("FAIL single_edge1: got wen=%0b count=%0d want wen=0 count=1", wbi.rf_wen, count);
        end
        idle_step();
        n_total++; if (wbi.rf_wen !== 1'b1 || wbi.rf_waddr !== 5'd5 || wbi.rf_wdata !== 64'h1234) begin
            n_bad++; $display("FAIL single_write: got wen=%0b addr=%0d data=%0h want 1/5/1234", wbi.rf_wen, wbi.rf_waddr, wbi.rf_wdata);
        end
        idle_step();
        n_total++; if (wbi.rf_wen !== 1'b0 || idle !== 1'b1) begin
            n_bad++; $display("FAIL single_after: got wen=%0b idle=%0b want 0/1", wbi.rf_wen, idle);
        end
    endtask

    task automatic test_dual();
        step(1'b1, 5'd7, 64'h7777, 1'b1, 5'd3, 64'h3333);
        n_total++; if (obs_lsu_ready !== 1'b1 || obs_alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL dual_ready: got lsu=%0b alu=%0b want 1/1", obs_lsu_ready, obs_alu_ready);
        end
        n_total++; if (count !== 3'd2) begin n_bad++; $display("FAIL dual_count: got %0d want 2", count); end
        idle_step();
        n_total++; if (wbi.rf_wen !== 1'b1 || wbi.rf_waddr !== 5'd7 || wbi.rf_wdata !== 64'h7777) begin
            n_bad++; $display("FAIL dual_first: got wen=%0b addr=%0d data=%0h want 1/7/7777", wbi.rf_wen, wbi.rf_waddr, wbi.rf_wdata);
        end
        idle_step();
        n_total++; if (wbi.rf_wen !== 1'b1 || wbi.rf_waddr !== 5'd3 || wbi.rf_wdata !== 64'h3333) begin
            n_bad++; $display("FAIL dual_second: got wen=%0b addr=%0d data=%0h want 1/3/3333", wbi.rf_wen, wbi.rf_waddr, wbi.rf_wdata);
        end
        idle_step();
        n_total++; if (wbi.rf_wen !== 1'b0) begin n_bad++; $display("FAIL dual_end: got wen=%0b want 0", wbi.rf_wen); end
    endtask

    task automatic test_rd_zero();
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 64'hDEAD);
        n_total++; if (obs_alu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %0b want 1", obs_alu_ready); end
        n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL x0_count: got %0d want 0", count); end
        for (int i = 0; i < 3; i++) begin
            idle_step();
            n_total++; if (wbi.rf_wen !== 1'b0) begin n_bad++; $display("FAIL x0_wen: cycle %0d got %0b want 0", i, wbi.rf_wen); end
        end
    endtask

    task automatic test_fill();
        logic [EW-1:0] ent;
        exp_q.delete();
        for (int i = 0; i < 5 + 6; i++) begin
            if (i < 5) step(1'b1, 5'(i + 1), {$urandom, $urandom}, 1'b1, 5'(i + 16), {$urandom, $urandom});
            else idle_step();
            n_total++; if (obs_lsu_ready !== m_lsu_ready || obs_alu_ready !== m_alu_ready) begin
                n_bad++; $display("FAIL fill_ready: cycle %0d got lsu=%0b alu=%0b want %0b/%0b", i, obs_lsu_ready, obs_alu_ready, m_lsu_ready, m_alu_ready);
            end
            n_total++; if (count > 3'd4 || count !== 3'(model_q.size())) begin
                n_bad++; $display("FAIL fill_count: cycle %0d got %0d want %0d", i, count, model_q.size());
            end
            if (wbi.rf_wen === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL fill_extra: got write addr=%0d want none", wbi.rf_waddr);
                end else begin
                    ent = exp_q.pop_front();
                    if ({wbi.rf_waddr, wbi.rf_wdata} !== ent) begin
                        n_bad++; $display("FAIL fill_order: got %0d/%0h want %0d/%0h", wbi.rf_waddr, wbi.rf_wdata, ent[EW-1:DW], ent[DW-1:0]);
                    end
                end
            end
        end
        n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fill_lost: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_random();
        logic          lv, av;
        logic [4:0]    lrd, ard;
        logic [EW-1:0] ent;
        exp_q.delete();
        for (int i = 0; i < 400 + 8; i++) begin
            lv  = (i < 400) && ($urandom_range(0, 3) != 0);
            av  = (i < 400) && ($urandom_range(0, 3) != 0);
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(lv, lrd, {$urandom, $urandom}, av, ard, {$urandom, $urandom});
            n_total++; if (obs_lsu_ready !== m_lsu_ready || obs_alu_ready !== m_alu_ready) begin
                n_bad++; $display("FAIL rand_ready: cycle %0d got lsu=%0b alu=%0b want %0b/%0b", i, obs_lsu_ready, obs_alu_ready, m_lsu_ready, m_alu_ready);
            end
            n_total++; if (wbi.rf_wen !== m_wen || wbi.rf_waddr !== m_waddr || wbi.rf_wdata !== m_wdata) begin
                n_bad++; $display("FAIL rand_port: cycle %0d got %0b/%0d/%0h want %0b/%0d/%0h", i, wbi.rf_wen, wbi.rf_waddr, wbi.rf_wdata, m_wen, m_waddr, m_wdata);
            end
            n_total++; if (count !== 3'(model_q.size()) || idle !== (model_q.size() == 0 && !m_wen)) begin
                n_bad++; $display("FAIL rand_count: cycle %0d got count=%0d idle=%0b want %0d", i, count, idle, model_q.size());
            end
            if (wbi.rf_wen === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra: got write addr=%0d want none", wbi.rf_waddr);
                end else begin
                    ent = exp_q.pop_front();
                    if ({wbi.rf_waddr, wbi.rf_wdata} !== ent) begin
                        n_bad++; $display("FAIL rand_order: got %0d/%0h want %0d/%0h", wbi.rf_waddr, wbi.rf_wdata, ent[EW-1:DW], ent[DW-1:0]);
                    end
                end
            end
        end
        n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_lost: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
        step(1'b1, 5'd4, 64'h44, 1'b1, 5'd5, 64'h55);
        n_total++; if (count !== 3'd3 || wbi.rf_wen !== 1'b1) begin
            n_bad++; $display("FAIL midrst_setup: got count=%0d wen=%0b want 3/1", count, wbi.rf_wen);
        end
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (wbi.rf_wen !== 1'b0 || wbi.rf_waddr !== 5'd0 || wbi.rf_wdata !== 64'd0 || count !== 3'd0 || idle !== 1'b1) begin
            n_bad++; $display("FAIL midrst_async: got wen=%0b addr=%0d data=%0h count=%0d idle=%0b want 0/0/0/0/1",
                              wbi.rf_wen, wbi.rf_waddr, wbi.rf_wdata, count, idle);
        end
        wbi.lsu_valid = 1'b0; wbi.alu_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            idle_step();
            n_total++; if (wbi.rf_wen !== 1'b0 || count !== 3'd0) begin
                n_bad++; $display("FAIL midrst_stale: cycle %0d got wen=%0b count=%0d want 0/0", i, wbi.rf_wen, count);
            end
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        step(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h11);
        step(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h22);
        wbi.alu_valid = 1'b0;
        byp_rs1 = 5'd9; byp_rs2 = 5'd0;
        #1;
        n_total++; if (byp_hit1 !== 1'b1 || byp_data1 !== 64'h22) begin
            n_bad++; $display("FAIL byp_young: got hit=%0b data=%0h want 1/22", byp_hit1, byp_data1);
        end
        n_total++; if (byp_hit2 !== 1'b0 || byp_data2 !== 64'd0) begin
            n_bad++; $display("FAIL byp_x0: got hit=%0b data=%0h want 0/0", byp_hit2, byp_data2);
        end
        byp_rs2 = 5'd10;
        #1;
        n_total++; if (byp_hit2 !== 1'b0 || byp_data2 !== 64'd0) begin
            n_bad++; $display("FAIL byp_miss: got hit=%0b data=%0h want 0/0", byp_hit2, byp_data2);
        end
        idle_step();
        n_total++; if (byp_hit1 !== 1'b1 || byp_data1 !== 64'h22) begin
            n_bad++; $display("FAIL byp_stage: got hit=%0b data=%0h want 1/22", byp_hit1, byp_data1);
        end
        byp_rs1 = 5'd0; byp_rs2 = 5'd0;
        repeat (3) idle_step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_alu();
        test_dual();
        test_rd_zero();
        test_fill();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
